// File: rtl/key_event_ctrl.sv
// key_event_ctrl: classifies debounced key presses into SINGLE / DOUBLE / LONG
// events (plus optional REPEAT while a long press is held). The events are
// delivered through a one-entry valid/ready buffer.
// Optional feature macro: KEY_EVT_AUTO_REPEAT_EN enables REPEAT events in LONG_HOLD.
module key_event_ctrl #(
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned LONG_CYC    = 1000000,
   parameter int unsigned DBL_GAP_CYC = 300000,
   parameter int unsigned REPEAT_CYC  = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_lvl,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   output logic       evt_drop,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS1,
      S_WAIT2,
      S_PRESS2,
      S_LONG_HOLD
   } state_t;

   localparam logic [1:0] EVT_REPEAT = 2'b00;
   localparam logic [1:0] EVT_SINGLE = 2'b01;
   localparam logic [1:0] EVT_DOUBLE = 2'b10;
   localparam logic [1:0] EVT_LONG   = 2'b11;

   localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DBL_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYC - 1);

`ifdef KEY_EVT_AUTO_REPEAT_EN
   localparam bit REPEAT_EN = 1'b1;
`else
   localparam bit REPEAT_EN = 1'b0;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cnt_clr;
   logic             lim_q;
   logic             lim_nxt;
   logic             key_q;
   logic             rise;
   logic             fall;
   logic             new_evt;
   logic [1:0]       new_code;
   logic             load;
   logic             drop;

   // Edge detection against the previous key sample.
   assign rise = key_lvl & ~key_q;
   assign fall = ~key_lvl & key_q;

   // State, counter, timeout flag and key sample registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         lim_q <= 1'b0;
         key_q <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         lim_q <= lim_nxt;
         key_q <= key_lvl;
         busy  <= (state_nxt != S_IDLE);
      end
   end

   // Next-state and event decision; edges always win over a coincident timeout.
   always_comb begin
      state_nxt = state;
      new_evt   = 1'b0;
      new_code  = EVT_SINGLE;
      cnt_clr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (rise) state_nxt = S_PRESS1;
         end
         S_PRESS1: begin
            if (fall) begin
               state_nxt = S_WAIT2;
            end else if (lim_q) begin
               state_nxt = S_LONG_HOLD;
               new_evt   = 1'b1;
               new_code  = EVT_LONG;
            end
         end
         S_WAIT2: begin
            if (rise) begin
               state_nxt = S_PRESS2;
            end else if (lim_q) begin
               state_nxt = S_IDLE;
               new_evt   = 1'b1;
               new_code  = EVT_SINGLE;
            end
         end
         S_PRESS2: begin
            if (fall) begin
               state_nxt = S_IDLE;
               new_evt   = 1'b1;
               new_code  = EVT_DOUBLE;
            end
         end
         S_LONG_HOLD: begin
            if (fall) begin
               state_nxt = S_IDLE;
            end else if (REPEAT_EN && lim_q) begin
               new_evt  = 1'b1;
               new_code = EVT_REPEAT;
               cnt_clr  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Counter clears on state change or repeat tick, otherwise saturates upward.
   always_comb begin
      cnt_nxt = cnt;
      if ((state_nxt != state) || cnt_clr) begin
         cnt_nxt = '0;
      end else if (cnt != '1) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // Timeout compare done one cycle early so lim_q is a plain flop.
   always_comb begin
      lim_nxt = 1'b0;
      case (state_nxt)
         S_PRESS1:    lim_nxt = (cnt_nxt == LONG_LIM);
         S_WAIT2:     lim_nxt = (cnt_nxt == GAP_LIM);
         S_LONG_HOLD: lim_nxt = (cnt_nxt == REP_LIM);
         default:     lim_nxt = 1'b0;
      endcase
   end

   // Buffer admission: load when empty or draining this cycle, else drop.
   always_comb begin
      load = new_evt & (~evt_valid | evt_ready);
      drop = new_evt & evt_valid & ~evt_ready;
   end

   // One-entry event buffer with drop pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_code  <= 2'b00;
         evt_drop  <= 1'b0;
      end else begin
         evt_drop <= drop;
         if (load) begin
            evt_valid <= 1'b1;
            evt_code  <= new_code;
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed self-checking bench for key_event_ctrl with short timing parameters.
module tb_key_event_ctrl;

   localparam int unsigned LONG_CYC    = 20;
   localparam int unsigned DBL_GAP_CYC = 10;
   localparam int unsigned REPEAT_CYC  = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_lvl;
   logic       evt_ready;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_drop;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;
   int ev_cnt = 0;
   int drop_cnt = 0;
   logic [1:0] last_code = 2'b00;
   int ev_base;
   int drop_base;
   int n;

   key_event_ctrl #(
      .CNT_W      (24),
      .LONG_CYC   (LONG_CYC),
      .DBL_GAP_CYC(DBL_GAP_CYC),
      .REPEAT_CYC (REPEAT_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_lvl  (key_lvl),
      .evt_ready(evt_ready),
      .evt_valid(evt_valid),
      .evt_code (evt_code),
      .evt_drop (evt_drop),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Log accepted events and drop pulses at the clock edge.
   always @(posedge clk) begin
      if (evt_valid && evt_ready) begin
         ev_cnt++;
         last_code = evt_code;
      end
      if (evt_drop) drop_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   // Edges until evt_valid shows, bounded by max.
   task automatic wait_evt(input int max, output int cnt_o);
      cnt_o = 0;
      while (!evt_valid && cnt_o < max) begin
         tick();
         cnt_o++;
      end
   endtask

   task automatic wait_drop(input int max, output int cnt_o);
      cnt_o = 0;
      while (!evt_drop && cnt_o < max) begin
         tick();
         cnt_o++;
      end
   endtask

   initial begin
      rst = 1'b1;
      key_lvl = 1'b0;
      evt_ready = 1'b1;
      ticks(3);
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_code", 32'(evt_code), 0);
      check("rst_drop", 32'(evt_drop), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      ticks(2);

      // 1: single press
      ev_base = ev_cnt;
      key_lvl = 1'b1;
      tick();
      check("t1_busy_press", 32'(busy), 1);
      ticks(4);
      key_lvl = 1'b0;
      wait_evt(40, n);
      check("t1_single_lat", 32'(n), 32'(DBL_GAP_CYC + 1));
      check("t1_single_code", 32'(evt_code), 1);
      check("t1_busy_after", 32'(busy), 0);
      ticks(30);
      check("t1_evt_count", 32'(ev_cnt - ev_base), 1);
      check("t1_valid_clear", 32'(evt_valid), 0);

      // 2: double press, gap of 4 released cycles
      ev_base = ev_cnt;
      key_lvl = 1'b1;
      ticks(5);
      key_lvl = 1'b0;
      ticks(4);
      check("t2_no_early_evt", 32'(evt_valid), 0);
      key_lvl = 1'b1;
      ticks(5);
      key_lvl = 1'b0;
      wait_evt(40, n);
      check("t2_double_lat", 32'(n), 1);
      check("t2_double_code", 32'(evt_code), 2);
      ticks(20);
      check("t2_evt_count", 32'(ev_cnt - ev_base), 1);
      check("t2_last_code", 32'(last_code), 2);

      // 3: long hold (41 sampled high edges)
      ev_base = ev_cnt;
      key_lvl = 1'b1;
      wait_evt(60, n);
      check("t3_long_lat", 32'(n), 32'(LONG_CYC + 1));
      check("t3_long_code", 32'(evt_code), 3);
      check("t3_busy_hold", 32'(busy), 1);
      ticks(20);
      key_lvl = 1'b0;
      ticks(11);
      check("t3_busy_after", 32'(busy), 0);
`ifdef KEY_EVT_AUTO_REPEAT_EN
      check("t3_evt_count", 32'(ev_cnt - ev_base), 5);
      check("t3_last_code", 32'(last_code), 0);
`else
      check("t3_evt_count", 32'(ev_cnt - ev_base), 1);
      check("t3_last_code", 32'(last_code), 3);
`endif

      // 4: consumer stalled, second event dropped
      ev_base = ev_cnt;
      drop_base = drop_cnt;
      evt_ready = 1'b0;
      key_lvl = 1'b1;
      ticks(5);
      key_lvl = 1'b0;
      wait_evt(40, n);
      check("t4_first_lat", 32'(n), 32'(DBL_GAP_CYC + 1));
      key_lvl = 1'b1;
      ticks(5);
      key_lvl = 1'b0;
      wait_drop(40, n);
      check("t4_drop_lat", 32'(n), 32'(DBL_GAP_CYC + 1));
      check("t4_held_valid", 32'(evt_valid), 1);
      check("t4_held_code", 32'(evt_code), 1);
      tick();
      check("t4_drop_pulse", 32'(evt_drop), 0);
      evt_ready = 1'b1;
      tick();
      check("t4_consumed", 32'(evt_valid), 0);
      check("t4_evt_count", 32'(ev_cnt - ev_base), 1);
      check("t4_drop_count", 32'(drop_cnt - drop_base), 1);
      ticks(5);

      // 5: reset while in WAIT2 with cnt=3
      ev_base = ev_cnt;
      key_lvl = 1'b1;
      ticks(5);
      key_lvl = 1'b0;
      ticks(4);
      rst = 1'b1;
      tick();
      check("t5_busy", 32'(busy), 0);
      check("t5_valid", 32'(evt_valid), 0);
      check("t5_code", 32'(evt_code), 0);
      check("t5_drop", 32'(evt_drop), 0);
      rst = 1'b0;
      ticks(20);
      check("t5_no_evt", 32'(ev_cnt - ev_base), 0);

      // 6: release on the same edge the long timeout is reached
      ev_base = ev_cnt;
      key_lvl = 1'b1;
      ticks(LONG_CYC);
      key_lvl = 1'b0;
      tick();
      check("t6_busy_wait2", 32'(busy), 1);
      check("t6_no_long", 32'(evt_valid), 0);
      wait_evt(40, n);
      check("t6_single_lat", 32'(n), 32'(DBL_GAP_CYC));
      check("t6_single_code", 32'(evt_code), 1);
      ticks(5);
      check("t6_evt_count", 32'(ev_cnt - ev_base), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
